// File: rtl/servo_pos_tracker.sv
// Per-axis servo position tracker: synchronises and debounces a comparator input,
// then ramps a saturating position up or down at a fixed step rate.
`timescale 1ns/1ps

module servo_pos_tracker #(
  parameter int CLK_FREQUENCY      = 50_000_000,
  parameter int POS_WIDTH          = 8,
  parameter int POS_MIN            = 0,
  parameter int POS_MAX            = 255,
  parameter int POS_INIT           = 128,
  parameter int DEBOUNCE_CYCLES    = 50_000,
  parameter int STEP_PERIOD_CYCLES = 500_000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 comp_async_i,
  input  logic                 enable_i,
  output logic [POS_WIDTH-1:0] pos_o,
  output logic                 pos_update_o,
  output logic                 limit_hi_o,
  output logic                 limit_lo_o,
  output logic [1:0]           state_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STEP_W = $clog2(STEP_PERIOD_CYCLES);

  localparam logic [DEB_W-1:0]     DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_PERIOD_CYCLES - 1);
  localparam logic [POS_WIDTH-1:0] P_MIN     = POS_WIDTH'(POS_MIN);
  localparam logic [POS_WIDTH-1:0] P_MAX     = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] P_INIT    = POS_WIDTH'(POS_INIT);

  if (CLK_FREQUENCY <= 0 || DEBOUNCE_CYCLES < 1 || STEP_PERIOD_CYCLES < 2 ||
      POS_MIN > POS_INIT || POS_INIT > POS_MAX) begin : g_bad_params
    $error("servo_pos_tracker: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN_UP = 2'b01,
    RUN_DN = 2'b10
  } state_t;

  state_t                state;
  logic                  sync1;
  logic                  sync2;
  logic                  deb;
  logic [DEB_W-1:0]      deb_cnt;
  logic [STEP_W-1:0]     step_cnt;
  logic                  step_tick;
  logic [POS_WIDTH-1:0]  pos;
  logic                  pos_update;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= comp_async_i;
      sync2 <= sync1;
    end
  end

  // The level only flips once a mismatch has persisted DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb     <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable_i) state <= deb ? RUN_UP : RUN_DN;
        RUN_UP:  if (!enable_i) state <= IDLE;
                 else if (!deb) state <= RUN_DN;
        RUN_DN:  if (!enable_i) state <= IDLE;
                 else if (deb) state <= RUN_UP;
        default: state <= IDLE;
      endcase
    end
  end

  assign step_tick = (state != IDLE) && (step_cnt == STEP_LAST);

  // Direction changes keep the cadence running; only IDLE restarts it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      step_cnt <= '0;
    end else if (state == IDLE || step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  // Limits are compared before stepping so full-range limits never wrap.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pos        <= P_INIT;
      pos_update <= 1'b0;
    end else begin
      pos_update <= 1'b0;
      if (step_tick) begin
        if (state == RUN_UP && pos != P_MAX) begin
          pos        <= pos + 1'b1;
          pos_update <= 1'b1;
        end else if (state == RUN_DN && pos != P_MIN) begin
          pos        <= pos - 1'b1;
          pos_update <= 1'b1;
        end
      end
    end
  end

  assign pos_o        = pos;
  assign pos_update_o = pos_update;
  assign limit_hi_o   = (pos == P_MAX);
  assign limit_lo_o   = (pos == P_MIN);
  assign state_o      = state;

endmodule

// File: doc/servo_pos_tracker.md
Name: servo_pos_tracker

Overview:
Per-axis upstream stage of the XY servo controller. Synchronises and debounces one asynchronous comparator input, then ramps a saturating servo position value up (comparator high) or down (comparator low) at a fixed step rate. The downstream PWM stage consumes pos_o; one instance is used per axis (X, Y).

Parameters:
CLK_FREQUENCY, 50_000_000, clock frequency in Hz (informational; documents the defaults below).
POS_WIDTH, 8, width of the position value.
POS_MIN, 0, lower saturation limit.
POS_MAX, 255, upper saturation limit.
POS_INIT, 128, position after reset; POS_MIN <= POS_INIT <= POS_MAX.
DEBOUNCE_CYCLES, 50_000, required stable cycles for a level change (1 ms); must be >= 1.
STEP_PERIOD_CYCLES, 500_000, clock cycles between position steps (10 ms); must be >= 2.

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-low reset
comp_async_i  in  1  asynchronous comparator input
enable_i  in  1  tracking enable (synchronous)
pos_o  out  POS_WIDTH  current servo position
pos_update_o  out  1  one-cycle pulse, high in the first cycle pos_o shows a new value
limit_hi_o  out  1  pos_o == POS_MAX
limit_lo_o  out  1  pos_o == POS_MIN
state_o  out  2  FSM state: 00 IDLE, 01 RUN_UP, 10 RUN_DN

Behaviour:
- Reset (reset_i = 0, takes effect immediately without a clock edge): sync flops = 0, debounced level = 0, debounce counter = 0, step counter = 0, state IDLE, pos_o = POS_INIT, pos_update_o = 0. limit flags reflect POS_INIT.
- Synchroniser: two flops. A new comp level is visible in sync2 after 2 edges.
- Debounce:
  - Counter clears whenever sync2 == debounced level.
  - On mismatch the counter increments. The debounced level takes sync2 on the edge where the counter == DEBOUNCE_CYCLES-1, and the counter clears on that edge.
  - A stable change therefore reaches the debounced level 2+DEBOUNCE_CYCLES edges after first sampling. A pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- FSM, registered, one edge after its inputs:
  - IDLE: enable_i = 1 -> RUN_UP if debounced = 1, else RUN_DN.
  - RUN_UP: enable_i = 0 -> IDLE; else debounced = 0 -> RUN_DN.
  - RUN_DN: enable_i = 0 -> IDLE; else debounced = 1 -> RUN_UP.
  - enable_i = 0 has priority over a direction change.
- Step counter:
  - Counts 0..STEP_PERIOD_CYCLES-1 only in RUN_UP or RUN_DN. Held at 0 in IDLE.
  - Step tick when count == STEP_PERIOD_CYCLES-1. The counter wraps to 0 on the tick.
  - The first tick occurs STEP_PERIOD_CYCLES cycles after entering a RUN state.
  - A direction change does not clear the counter.
- Position update on a tick, using the current (pre-transition) state:
  - RUN_UP: pos + 1, saturating at POS_MAX.
  - RUN_DN: pos - 1, saturating at POS_MIN.
  - If the tick coincides with an FSM transition, the old direction applies.
  - No update in IDLE.
- pos_update_o is registered: high for exactly one cycle, concurrent with the new pos_o. It is not asserted when saturation blocks the step.
- Arithmetic: no wrap-around. Compare before increment/decrement so that POS_MAX = 2^POS_WIDTH-1 and POS_MIN = 0 are safe.
- limit_hi_o and limit_lo_o are decoded from the pos register (no added latency).

Test Plan:
Bench parameters: POS_MIN=10, POS_MAX=20, POS_INIT=15, DEBOUNCE_CYCLES=4, STEP_PERIOD_CYCLES=10.
1. Reset with enable_i = 0 -> pos_o = 15, state_o = 00, pos_update_o = 0, limit_hi_o = 0, limit_lo_o = 0, and outputs stay unchanged for 100 cycles.
2. comp = 1 and enable = 1 held -> debounced level after 6 edges, state 01 one edge later. Steps every 10 cycles give pos 16, 17, 18, 19, 20 with 5 single-cycle pulses. Then limit_hi_o = 1 and no further pulses for 50 cycles.
3. Glitch: comp low for 3 cycles while in RUN_UP -> state stays 01 and the step cadence is undisturbed.
4. comp = 0 held from pos 20 -> state 10 after 7 edges. pos decrements 19 down to 10 every 10 cycles (counter not reset), then limit_lo_o = 1 and pulses stop.
5. enable_i deasserted mid-ramp at pos 13 -> state 00 next edge, pos holds 13. On re-enable, the first step occurs exactly 10 cycles after entering RUN.
6. reset_i driven low between clock edges mid-ramp -> pos_o = 15 and state_o = 00 immediately, before the next edge. After release, behaviour matches scenario 1.
